pms_control_fsm: RTL and testbench

- Multi-cycle control sequencer on the consumer side of the program management system.
- Reads the fetched instruction word and immediate, then drives every strobe the PMS accepts: PC/RA writes, memory reads/writes, source selects and restore.
- Also issues ALU/register-file controls, counts retired instructions and halts on HALT or ALU timeout.

---
 rtl/pms_ctrl_pkg.sv | 50 +++++
 rtl/pms_control_fsm_if.sv | 42 ++++
 rtl/pms_ctrl_timeout.sv | 25 ++
 rtl/pms_control_fsm.sv | 140 ++++++++++++++
 tb/tb_pms_control_fsm.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pms_ctrl_pkg.sv
// Shared opcode constants, sequencer states and control-word layout for the
// PMS consumer-side control sequencer.
package pms_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_BRC  = 4'h5;
  localparam logic [3:0] OP_J    = 4'h6;
  localparam logic [3:0] OP_JAL  = 4'h7;
  localparam logic [3:0] OP_RET  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, IMM, EXEC, ALU_WAIT, MEM, WB,
    BRANCH, PC_INC2, PC_INC, RET, RETIRE, HALT
  } state_t;

  typedef struct packed {
    logic       write_pc;
    logic       write_ra;
    logic       pc_src;
    logic       imr_pc;
    logic       cond_bop;
    logic       restore;
    logic       mem_src;
    logic       mem_w2;
    logic       mem_r1;
    logic       mem_r2;
    logic       alu_go;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       reg_write;
    logic       illegal_op;
    logic       halted;
  } ctl_t;

  // Opcodes followed by an immediate word fetched on port 2.
  function automatic logic is_two_word(input logic [3:0] op);
    return (op >= OP_ALUI) && (op <= OP_JAL);
  endfunction

  function automatic logic is_defined(input logic [3:0] op);
    return is_two_word(op) || (op == OP_NOP) || (op == OP_ALU) ||
           (op == OP_RET) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/pms_control_fsm_if.sv
// Strobe/status bundle between the control sequencer (master) and the
// PMS/datapath (slave).
interface pms_control_fsm_if #(parameter int INSTRET_W = 16);

  logic [15:0]          IR;
  logic                 cond_true;
  logic                 alu_done;
  logic                 writePC;
  logic                 writeRA;
  logic                 PCsrc;
  logic                 ImRPC;
  logic                 conditionalBop;
  logic                 restore;
  logic                 Memsrc;
  logic                 MemW1;
  logic                 MemW2;
  logic                 MemR1;
  logic                 MemR2;
  logic                 alu_go;
  logic [3:0]           alu_op;
  logic                 alu_src_imm;
  logic                 reg_write;
  logic                 illegal_op;
  logic                 halted;
  logic                 fault;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  IR, cond_true, alu_done,
    output writePC, writeRA, PCsrc, ImRPC, conditionalBop, restore, Memsrc,
           MemW1, MemW2, MemR1, MemR2, alu_go, alu_op, alu_src_imm,
           reg_write, illegal_op, halted, fault, instret
  );

  modport slave (
    output IR, cond_true, alu_done,
    input  writePC, writeRA, PCsrc, ImRPC, conditionalBop, restore, Memsrc,
           MemW1, MemW2, MemR1, MemR2, alu_go, alu_op, alu_src_imm,
           reg_write, illegal_op, halted, fault, instret
  );

endinterface

// File: rtl/pms_ctrl_timeout.sv
// ALU_WAIT cycle counter; expired flags the last permitted wait cycle so the
// counter reaches ALU_TIMEOUT on the same edge the sequencer gives up.
module pms_ctrl_timeout #(
  parameter int ALU_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == CW'(ALU_TIMEOUT - 1));

endmodule

// File: rtl/pms_control_fsm.sv
// Multi-cycle control sequencer: walks each instruction through fetch,
// immediate, ALU/memory and PC update steps with registered strobes.
module pms_control_fsm
  import pms_ctrl_pkg::*;
#(
  parameter int ALU_TIMEOUT = 16,
  parameter int INSTRET_W   = 16
) (
  input logic                clk,
  input logic                reset,
  pms_control_fsm_if.master  bus
);

  state_t               state, state_nx;
  ctl_t                 ctl, ctl_nx;
  logic                 fault;
  logic [INSTRET_W-1:0] instret;
  logic [3:0]           op;
  logic                 tmo_clear, tmo_enable, tmo_expired;

  assign op         = bus.IR[15:12];
  assign tmo_clear  = (state == EXEC);
  assign tmo_enable = (state == ALU_WAIT) && !bus.alu_done;

  pms_ctrl_timeout #(.ALU_TIMEOUT(ALU_TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nx = state;
    case (state)
      BOOT:     state_nx = FETCH;
      FETCH:    state_nx = DECODE;
      DECODE: begin
        if (is_two_word(op))    state_nx = IMM;
        else if (op == OP_ALU)  state_nx = EXEC;
        else if (op == OP_RET)  state_nx = RET;
        else if (op == OP_HALT) state_nx = HALT;
        else                    state_nx = PC_INC;
      end
      IMM: begin
        if (op == OP_ALUI)                      state_nx = EXEC;
        else if ((op == OP_LW) || (op == OP_SW)) state_nx = MEM;
        else                                    state_nx = BRANCH;
      end
      EXEC:     state_nx = ALU_WAIT;
      ALU_WAIT: begin
        if (bus.alu_done)     state_nx = WB;
        else if (tmo_expired) state_nx = HALT;
      end
      MEM:      state_nx = (op == OP_SW) ? PC_INC2 : WB;
      WB:       state_nx = is_two_word(op) ? PC_INC2 : PC_INC;
      // The registered PC write tells whether the branch was taken.
      BRANCH:   state_nx = ctl.write_pc ? RETIRE : PC_INC2;
      PC_INC2:  state_nx = PC_INC;
      PC_INC:   state_nx = RETIRE;
      RET:      state_nx = RETIRE;
      RETIRE:   state_nx = FETCH;
      HALT:     state_nx = HALT;
      default:  state_nx = BOOT;
    endcase
  end

  always_comb begin
    ctl_nx = '0;
    case (state_nx)
      FETCH:   ctl_nx.mem_r1 = 1'b1;
      DECODE:  ctl_nx.illegal_op = !is_defined(op);
      IMM:     ctl_nx.mem_r2 = 1'b1;
      EXEC: begin
        ctl_nx.alu_go      = 1'b1;
        ctl_nx.alu_op      = bus.IR[3:0];
        ctl_nx.alu_src_imm = (op == OP_ALUI);
      end
      MEM: begin
        ctl_nx.mem_src = 1'b1;
        ctl_nx.mem_w2  = (op == OP_SW);
        ctl_nx.mem_r2  = (op != OP_SW);
      end
      WB:      ctl_nx.reg_write = 1'b1;
      BRANCH: begin
        if ((op != OP_BRC) || bus.cond_true) begin
          ctl_nx.write_pc = 1'b1;
          ctl_nx.pc_src   = 1'b1;
          ctl_nx.imr_pc   = 1'b1;
          ctl_nx.cond_bop = (op == OP_BRC);
          ctl_nx.write_ra = (op == OP_JAL);
        end
      end
      PC_INC2, PC_INC: ctl_nx.write_pc = 1'b1;
      RET: begin
        ctl_nx.restore  = 1'b1;
        ctl_nx.write_pc = 1'b1;
      end
      HALT:    ctl_nx.halted = 1'b1;
      default: ctl_nx = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      ctl     <= '0;
      fault   <= 1'b0;
      instret <= '0;
    end else begin
      state <= state_nx;
      ctl   <= ctl_nx;
      if ((state == ALU_WAIT) && tmo_expired) fault <= 1'b1;
      // A HALT instruction retires on entry; a timeout entry does not.
      if ((state_nx == RETIRE) || ((state == DECODE) && (state_nx == HALT)))
        instret <= instret + 1'b1;
    end
  end

  assign bus.writePC        = ctl.write_pc;
  assign bus.writeRA        = ctl.write_ra;
  assign bus.PCsrc          = ctl.pc_src;
  assign bus.ImRPC          = ctl.imr_pc;
  assign bus.conditionalBop = ctl.cond_bop;
  assign bus.restore        = ctl.restore;
  assign bus.Memsrc         = ctl.mem_src;
  assign bus.MemW1          = 1'b0;
  assign bus.MemW2          = ctl.mem_w2;
  assign bus.MemR1          = ctl.mem_r1;
  assign bus.MemR2          = ctl.mem_r2;
  assign bus.alu_go         = ctl.alu_go;
  assign bus.alu_op         = ctl.alu_op;
  assign bus.alu_src_imm    = ctl.alu_src_imm;
  assign bus.reg_write      = ctl.reg_write;
  assign bus.illegal_op     = ctl.illegal_op;
  assign bus.halted         = ctl.halted;
  assign bus.fault          = fault;
  assign bus.instret        = instret;

endmodule

// File: tb/tb_pms_control_fsm.sv
// Directed bench: per-instruction expected strobe traces built from the
// instruction rules, compared every cycle, plus literal pins.
module tb_pms_control_fsm;

  localparam int TMO = 16;

  localparam logic [20:0] B_WPC    = 21'd1 << 20;
  localparam logic [20:0] B_WRA    = 21'd1 << 19;
  localparam logic [20:0] B_PCSRC  = 21'd1 << 18;
  localparam logic [20:0] B_IMRPC  = 21'd1 << 17;
  localparam logic [20:0] B_CBOP   = 21'd1 << 16;
  localparam logic [20:0] B_REST   = 21'd1 << 15;
  localparam logic [20:0] B_MEMSRC = 21'd1 << 14;
  localparam logic [20:0] B_MEMW2  = 21'd1 << 12;
  localparam logic [20:0] B_MEMR1  = 21'd1 << 11;
  localparam logic [20:0] B_MEMR2  = 21'd1 << 10;
  localparam logic [20:0] B_ALUGO  = 21'd1 << 9;
  localparam logic [20:0] B_SRCIMM = 21'd1 << 4;
  localparam logic [20:0] B_REGW   = 21'd1 << 3;
  localparam logic [20:0] B_ILL    = 21'd1 << 2;
  localparam logic [20:0] B_HALTED = 21'd1 << 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pms_control_fsm_if #(.INSTRET_W(16)) bus();

  pms_control_fsm #(.ALU_TIMEOUT(TMO), .INSTRET_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [20:0] o;
    logic [15:0] instret;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_instret;
  bit          m_fault;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          s;
  int t_alugo, t_regw, t_wpcinc, t_imrpc, t_cbop, t_rapc, t_rest, t_ill;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  function automatic logic [20:0] observe();
    return {bus.writePC, bus.writeRA, bus.PCsrc, bus.ImRPC, bus.conditionalBop,
            bus.restore, bus.Memsrc, bus.MemW1, bus.MemW2, bus.MemR1, bus.MemR2,
            bus.alu_go, bus.alu_op, bus.alu_src_imm, bus.reg_write,
            bus.illegal_op, bus.halted, bus.fault};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input logic [20:0] o, input logic done = 1'b0);
    exp_q.push_back('{o: o | {20'b0, m_fault}, instret: m_instret, done: done});
  endtask

  task automatic retire();
    m_instret++;
    push(21'd0);
  endtask

  // Expected per-cycle trace of one instruction, starting at its fetch cycle.
  task automatic gen(input logic [15:0] ir, input logic cond, input int waits,
                     input bit done_last, input int halt_cycles);
    logic [3:0] op;
    bit two, defd;
    op   = ir[15:12];
    two  = (op >= 4'h2) && (op <= 4'h7);
    defd = two || (op == 4'h0) || (op == 4'h1) || (op == 4'h8) || (op == 4'hF);
    push(B_MEMR1);
    push(defd ? 21'd0 : B_ILL);
    if (op == 4'hF) begin
      m_instret++;
      repeat (halt_cycles) push(B_HALTED);
      return;
    end
    if (op == 4'h8) begin
      push(B_WPC | B_REST);
      retire();
      return;
    end
    if (two) push(B_MEMR2);
    if ((op == 4'h1) || (op == 4'h2)) begin
      push(B_ALUGO | ({17'b0, ir[3:0]} << 5) | ((op == 4'h2) ? B_SRCIMM : 21'd0));
      for (int i = 0; i < waits; i++) push(21'd0, done_last && (i == waits - 1));
      if (!done_last) begin
        m_fault = 1'b1;
        repeat (halt_cycles) push(B_HALTED);
        return;
      end
      push(B_REGW);
    end else if (op == 4'h3) begin
      push(B_MEMSRC | B_MEMR2);
      push(B_REGW);
    end else if (op == 4'h4) begin
      push(B_MEMSRC | B_MEMW2);
    end else if (two) begin
      if ((op != 4'h5) || cond) begin
        push(B_WPC | B_PCSRC | B_IMRPC | ((op == 4'h5) ? B_CBOP : 21'd0) |
             ((op == 4'h7) ? B_WRA : 21'd0));
        retire();
        return;
      end
      push(21'd0);
    end
    if (two) push(B_WPC);
    push(B_WPC);
    retire();
  endtask

  task automatic drain(input int max_steps, output int start_cyc);
    exp_t e;
    logic [20:0] o;
    int n;
    n = 0;
    start_cyc = -1;
    while ((exp_q.size() > 0) && (n < max_steps)) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (n == 0) start_cyc = cyc;
      n++;
      o = observe();
      check("cycle_outputs", {27'b0, o, bus.instret}, {27'b0, e.o, e.instret});
      if (o[9]) t_alugo++;
      if (o[3]) t_regw++;
      if (o[20] && !o[18]) t_wpcinc++;
      if (o[17]) t_imrpc++;
      if (o[16]) t_cbop++;
      if (o[19] && o[20]) t_rapc++;
      if (o[15]) t_rest++;
      if (o[2]) t_ill++;
      bus.alu_done = e.done;
    end
  endtask

  task automatic clear_tallies();
    t_alugo = 0; t_regw = 0; t_wpcinc = 0; t_imrpc = 0;
    t_cbop = 0;  t_rapc = 0; t_rest = 0;   t_ill = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    bus.alu_done = 1'b0;
    m_instret = '0;
    m_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {27'b0, observe(), bus.instret}, 64'd0);
    reset = 1'b0;
    #1;
    check("boot_state", {27'b0, observe(), bus.instret}, 64'd0);
  endtask

  task automatic run(input logic [15:0] ir, input logic cond, input int waits,
                     input bit done_last, input int halt_cycles);
    clear_tallies();
    bus.IR = ir;
    bus.cond_true = cond;
    gen(ir, cond, waits, done_last, halt_cycles);
    drain(200, s);
  endtask

  initial begin
    bus.IR = 16'h0000;
    bus.cond_true = 1'b0;
    bus.alu_done = 1'b0;
    clear_tallies();
    do_reset();

    run(16'h0000, 1'b0, 0, 1'b0, 0);
    check("nop_first_fetch_cycle", s, 1);
    check("nop_instret", bus.instret, 16'd1);

    run(16'h2005, 1'b0, 3, 1'b1, 0);
    check("alui_fetch_cycle5", s, 5);
    check("alui_alu_go_count", t_alugo, 1);
    check("alui_reg_write_count", t_regw, 1);
    check("alui_pc_plus1_writes", t_wpcinc, 2);
    check("alui_instret", bus.instret, 16'd2);

    run(16'h3000, 1'b0, 0, 1'b0, 0);
    check("lw_instret", bus.instret, 16'd3);

    run(16'h5000, 1'b1, 0, 1'b0, 0);
    check("brc_taken_imrpc", t_imrpc, 1);
    check("brc_taken_cbop", t_cbop, 1);

    run(16'h5000, 1'b0, 0, 1'b0, 0);
    check("brc_not_taken_imrpc", t_imrpc, 0);
    check("brc_not_taken_pc_plus1", t_wpcinc, 2);
    check("brc_not_taken_cbop", t_cbop, 0);

    run(16'h7000, 1'b0, 0, 1'b0, 0);
    check("jal_ra_with_pc", t_rapc, 1);

    run(16'h8000, 1'b0, 0, 1'b0, 0);
    check("ret_restore", t_rest, 1);
    check("ret_instret", bus.instret, 16'd7);

    run(16'h1003, 1'b0, TMO, 1'b1, 0);
    check("done_at_limit_no_fault", bus.fault, 1'b0);
    check("done_at_limit_instret", bus.instret, 16'd8);

    run(16'h9000, 1'b0, 0, 1'b0, 0);
    check("illegal_pulse_count", t_ill, 1);
    check("illegal_instret", bus.instret, 16'd9);

    run(16'h1000, 1'b0, TMO, 1'b0, 4);
    check("timeout_halted", bus.halted, 1'b1);
    check("timeout_fault", bus.fault, 1'b1);
    check("timeout_instret", bus.instret, 16'd9);

    do_reset();
    check("reset_clears_fault", bus.fault, 1'b0);

    run(16'h6000, 1'b0, 0, 1'b0, 0);
    check("j_instret", bus.instret, 16'd1);

    clear_tallies();
    bus.IR = 16'h4000;
    gen(16'h4000, 1'b0, 0, 1'b0, 0);
    drain(4, s);
    check("sw_mem_store", bus.MemW2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_during_sw", {27'b0, observe(), bus.instret}, 64'd0);
    do_reset();

    run(16'hF000, 1'b0, 0, 1'b0, 3);
    check("halt_instr_halted", bus.halted, 1'b1);
    check("halt_instr_instret", bus.instret, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
